// File: rtl/usb_pkg.sv
// Shared USB token constants and the token transmitter state type.
package usb_pkg;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SOF   = 4'b0101;
  localparam logic [3:0] PID_SETUP = 4'b1101;

  localparam logic [7:0] TOKEN_SYNC_PAT = 8'h80;

  localparam int unsigned CNT_W = 4;

  // Last counter value of each fixed-length field
  localparam logic [CNT_W-1:0] LAST_BYTE_BIT = 4'd7;
  localparam logic [CNT_W-1:0] LAST_DATA_BIT = 4'd10;
  localparam logic [CNT_W-1:0] LAST_CRC_BIT  = 4'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PID,
    ST_DATA,
    ST_LOAD,
    ST_CRC,
    ST_ACK
  } tx_state_t;

endpackage

// File: rtl/counter.sv
// Generic up-counter with synchronous clear taking priority over enable.
module counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  // Count register: clear wins, otherwise step when enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/token_pkt_tx.sv
// USB token packet serializer: SYNC, PID, ADDR/ENDP and CRC5 from an
// external crc5 block, one bit per cycle, LSB first per field.
module token_pkt_tx
  import usb_pkg::*;
#(
  parameter logic [7:0]  SYNC_PAT = TOKEN_SYNC_PAT,
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned ENDP_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_start,
  input  logic [3:0]        pid,
  input  logic [ADDR_W-1:0] addr,
  input  logic [ENDP_W-1:0] endp,
  output logic              busy,
  output logic              out_bit,
  output logic              out_valid,
  output logic              out_eop,
  output logic              crc5_start,
  output logic              crc5_s_in,
  output logic              crc5_rec,
  input  logic              crc5_out,
  input  logic              crc5_ready,
  input  logic              crc5_done
);

  tx_state_t                  state;
  tx_state_t                  state_next;
  logic [CNT_W-1:0]           cnt;
  logic [3:0]                 pid_q;
  logic [ADDR_W+ENDP_W-1:0]   data_q;
  logic [7:0]                 pid_byte;

  assign pid_byte = {~pid_q, pid_q};

  // Bit counter restarts at every state change
  counter #(.W(CNT_W)) u_bit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_next != state),
    .en    (state != ST_IDLE),
    .count (cnt)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Capture the token fields only when a request is accepted in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pid_q  <= '0;
      data_q <= '0;
    end else if (state == ST_IDLE && tx_start) begin
      pid_q  <= pid;
      data_q <= {endp, addr};
    end
  end

  // Next-state and field mux; all outputs decode from state and counter
  always_comb begin
    state_next = state;
    busy       = (state != ST_IDLE);
    out_bit    = 1'b0;
    out_valid  = 1'b0;
    out_eop    = 1'b0;
    crc5_start = 1'b0;
    crc5_s_in  = 1'b0;
    crc5_rec   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (tx_start) state_next = ST_SYNC;
      end
      ST_SYNC: begin
        out_valid = 1'b1;
        out_bit   = SYNC_PAT[cnt[2:0]];
        if (cnt == LAST_BYTE_BIT) state_next = ST_PID;
      end
      ST_PID: begin
        out_valid = 1'b1;
        out_bit   = pid_byte[cnt[2:0]];
        if (cnt == LAST_BYTE_BIT) begin
          crc5_start = 1'b1;
          state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        out_valid = 1'b1;
        out_bit   = data_q[cnt];
        crc5_s_in = data_q[cnt];
        if (cnt == LAST_DATA_BIT) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        state_next = ST_CRC;
      end
      ST_CRC: begin
        // A dropped ready (early or late) ends the field; ACK still runs
        if (crc5_ready) begin
          out_valid = 1'b1;
          out_bit   = crc5_out;
          if (cnt == LAST_CRC_BIT) state_next = ST_ACK;
        end else begin
          state_next = ST_ACK;
        end
      end
      ST_ACK: begin
        if (crc5_done) begin
          crc5_rec   = 1'b1;
          out_eop    = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_token_pkt_tx.sv
// Bench for token_pkt_tx with a behavioural crc5 partner.
module tb_token_pkt_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_start;
  logic [3:0] pid;
  logic [6:0] addr;
  logic [3:0] endp;
  logic       busy, out_bit, out_valid, out_eop;
  logic       crc5_start, crc5_s_in, crc5_rec;
  logic       crc5_out, crc5_ready, crc5_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  token_pkt_tx #(.SYNC_PAT(8'h80), .ADDR_W(7), .ENDP_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_start   (tx_start),
    .pid        (pid),
    .addr       (addr),
    .endp       (endp),
    .busy       (busy),
    .out_bit    (out_bit),
    .out_valid  (out_valid),
    .out_eop    (out_eop),
    .crc5_start (crc5_start),
    .crc5_s_in  (crc5_s_in),
    .crc5_rec   (crc5_rec),
    .crc5_out   (crc5_out),
    .crc5_ready (crc5_ready),
    .crc5_done  (crc5_done)
  );

  // Reference serial CRC5 step: poly x^5+x^2+1
  function automatic logic [4:0] crc_step(input logic [4:0] c, input logic b);
    logic fb;
    fb = b ^ c[4];
    return {c[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
  endfunction

  // Behavioural crc5: 11 shift cycles after start, one load cycle,
  // five ready cycles MSB first of the complement, then done until rec.
  typedef enum logic [2:0] {M_IDLE, M_SHIFT, M_LOAD, M_OUT, M_DONE} mph_t;
  mph_t       m_ph;
  logic [4:0] m_crc;
  int         m_n;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph <= M_IDLE; m_crc <= 5'h1f; m_n <= 0;
      crc5_out <= 1'b0; crc5_ready <= 1'b0; crc5_done <= 1'b0;
    end else begin
      case (m_ph)
        M_IDLE: if (crc5_start) begin m_crc <= 5'h1f; m_n <= 0; m_ph <= M_SHIFT; end
        M_SHIFT: begin
          m_crc <= crc_step(m_crc, crc5_s_in);
          m_n   <= m_n + 1;
          if (m_n == 10) m_ph <= M_LOAD;
        end
        M_LOAD: begin
          m_ph <= M_OUT; m_n <= 0;
          crc5_ready <= 1'b1; crc5_out <= ~m_crc[4];
        end
        M_OUT: begin
          if (m_n == 4) begin
            crc5_ready <= 1'b0; crc5_done <= 1'b1; m_ph <= M_DONE;
          end else begin
            m_n <= m_n + 1; crc5_out <= ~m_crc[3-m_n];
          end
        end
        M_DONE: if (crc5_rec) begin crc5_done <= 1'b0; m_ph <= M_IDLE; end
        default: m_ph <= M_IDLE;
      endcase
    end
  end

  function automatic logic [31:0] exp_stream(input logic [3:0] p, input logic [6:0] a,
                                             input logic [3:0] e);
    logic [31:0] s;
    logic [7:0]  sy;
    logic [7:0]  pb;
    logic [10:0] d;
    logic [4:0]  c;
    s = '0; sy = 8'h80; pb = {~p, p}; d = {e, a}; c = 5'h1f;
    for (int i = 0; i < 8; i++) s = {s[30:0], sy[i]};
    for (int i = 0; i < 8; i++) s = {s[30:0], pb[i]};
    for (int i = 0; i < 11; i++) begin
      s = {s[30:0], d[i]};
      c = crc_step(c, d[i]);
    end
    c = ~c;
    for (int i = 4; i >= 0; i--) s = {s[30:0], c[i]};
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Called at a negedge with the DUT in IDLE; drives one request and
  // collects the stream until busy falls (bounded).
  task automatic run_pkt(input logic [3:0] p, input logic [6:0] a, input logic [3:0] e,
                         input bit inject, output logic [31:0] got, output int nbits,
                         output int eops, output int gaps, output int idle_at,
                         output int viol);
    got = '0; nbits = 0; eops = 0; gaps = 0; idle_at = -1; viol = 0;
    pid = p; addr = a; endp = e; tx_start = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i == 1) tx_start = 1'b0;
      if (inject && i == 20) begin tx_start = 1'b1; pid = ~p; addr = ~a; endp = ~e; end
      if (inject && i == 21) tx_start = 1'b0;
      if (out_valid) begin got = {got[30:0], out_bit}; nbits++; end
      if (out_eop) eops++;
      if (busy && !out_valid && !out_eop) gaps++;
      if ((crc5_s_in && !(out_valid && out_bit)) || (crc5_start && crc5_rec)) viol++;
      if (!busy) begin idle_at = i; break; end
    end
  endtask

  task automatic pkt_check(input string tag, input logic [3:0] p, input logic [6:0] a,
                           input logic [3:0] e, input logic [31:0] exp, input bit inject);
    logic [31:0] got;
    int nbits, eops, gaps, idle_at, viol;
    run_pkt(p, a, e, inject, got, nbits, eops, gaps, idle_at, viol);
    check({tag, "_stream"}, got, exp);
    check({tag, "_nbits"}, nbits, 32);
    check({tag, "_eop"}, eops, 1);
    check({tag, "_bubble"}, gaps, 1);
    check({tag, "_idle_at"}, idle_at, 35);
    check({tag, "_ctrl"}, viol, 0);
  endtask

  typedef struct {
    logic [3:0]  pid;
    logic [6:0]  addr;
    logic [3:0]  endp;
    logic [31:0] wire_bits;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int bad;
    int eops;

    vecs[0] = '{4'b1001, 7'h15, 4'hE, 32'b00000001_10010110_10101000111_10111};
    vecs[1] = '{4'b1101, 7'h00, 4'h0, 32'b00000001_10110100_00000000000_01000};
    vecs[2] = '{4'b0001, 7'h7F, 4'hF, 32'b00000001_10000111_11111111111_00010};
    vecs[3] = '{4'b0101, 7'h01, 4'h0, 32'b00000001_10100101_10000000000_10111};

    rst_n = 1'b0; tx_start = 1'b0; pid = '0; addr = '0; endp = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if ({busy, out_bit, out_valid, out_eop, crc5_start, crc5_s_in, crc5_rec} != 7'b0) bad++;
    end
    check("reset_idle_outputs", bad, 0);

    // Table vectors, issued back-to-back
    for (int i = 0; i < 4; i++)
      pkt_check($sformatf("vec%0d", i), vecs[i].pid, vecs[i].addr, vecs[i].endp,
                vecs[i].wire_bits, 1'b0);

    // Request during DATA is ignored; the next one follows immediately
    pkt_check("inject", 4'b1001, 7'h15, 4'hE, vecs[0].wire_bits, 1'b1);
    pkt_check("after_inject", 4'b1101, 7'h00, 4'h0, vecs[1].wire_bits, 1'b0);

    // Reset while the CRC field is on the wire
    pid = 4'b0001; addr = 7'h2A; endp = 4'h3; tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (29) @(negedge clk);
    check("pre_reset_crc_valid", {31'b0, out_valid}, 1);
    rst_n = 1'b0;
    #1;
    check("reset_mid_crc_outputs",
          {25'b0, busy, out_bit, out_valid, out_eop, crc5_start, crc5_s_in, crc5_rec}, 0);
    eops = 0;
    repeat (2) begin @(negedge clk); if (out_eop) eops++; end
    rst_n = 1'b1;
    repeat (5) begin @(negedge clk); if (out_eop) eops++; end
    check("reset_no_eop", eops, 0);
    pkt_check("after_reset", 4'b0001, 7'h2A, 4'h3, exp_stream(4'b0001, 7'h2A, 4'h3), 1'b0);

    // Random tokens against the reference CRC
    for (int unsigned k = 0; k < 1000; k++) begin
      logic [3:0] rp;
      logic [6:0] ra;
      logic [3:0] re;
      rp = 4'($urandom_range(0, 15));
      ra = 7'($urandom_range(0, 127));
      re = 4'($urandom_range(0, 15));
      pkt_check($sformatf("rand%0d", k), rp, ra, re, exp_stream(rp, ra, re), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
